// File: rtl/tpram_stream_reader_pkg.sv
// Shared definitions for the TPRAM read-stream engine: default widths and FSM state encoding.
package tpram_stream_reader_pkg;

    localparam int ADDR_W_DEF    = 8;
    localparam int DATA_W_DEF    = 16;
    localparam int LEN_W_DEF     = 9;
    localparam int BUF_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/tpram_stream_reader_if.sv
// Bundle of job control, TPRAM port-B and output stream signals for the read engine.
interface tpram_stream_reader_if
    import tpram_stream_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) ();

    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              ram_enb;
    logic [ADDR_W-1:0] ram_addrb;
    logic [DATA_W-1:0] ram_data_o_b;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    // master is the read engine itself; slave is the job issuer, RAM and consumer side
    modport master (
        input  start, start_addr, len, ram_data_o_b, m_ready,
        output busy, done, ram_enb, ram_addrb, m_valid, m_data, m_last
    );

    modport slave (
        output start, start_addr, len, ram_data_o_b, m_ready,
        input  busy, done, ram_enb, ram_addrb, m_valid, m_data, m_last
    );

endinterface

// File: rtl/tpram_stream_reader_rd_fifo.sv
// Small synchronous FIFO holding captured RAM words plus their last flag.
module tpram_rd_fifo #(
    parameter  int WIDTH = 17,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] headData_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    // a push into a full FIFO is still accepted when the head leaves in the same cycle
    assign doPop  = pop_i && (count_q != '0);
    assign doPush = push_i && ((count_q != CNT_W'(DEPTH)) || doPop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (doPush && !doPop) begin
                count_q <= count_q + 1'b1;
            end else if (doPop && !doPush) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    assign headData_o = mem_q[rdPtr_q];
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/tpram_stream_reader.sv
// Read-side engine for the two-port RAM: issues port-B reads for a job and streams the words
// out on a valid/ready interface, with a credit check so the output buffer can never overflow.
module tpram_stream_reader
    import tpram_stream_reader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
    input logic                  clk,
    input logic                  rst,
    tpram_stream_reader_if.master bus
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    rd_state_e         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remain_q;
    logic              ramEnb_q;
    logic [ADDR_W-1:0] ramAddrb_q;
    logic              enbLast_q;
    logic              inflight_q;
    logic              inflightLast_q;
    logic              busy_q;
    logic              done_q;

    logic [DATA_W:0]   fifoHead;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [CNT_W-1:0]  fifoCount;
    logic              popFire;
    logic [OCC_W-1:0]  occNext;
    logic              creditOk;
    logic              drainDone;

    tpram_rd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (inflight_q),
        .pushData_i ({inflightLast_q, bus.ram_data_o_b}),
        .pop_i      (popFire),
        .headData_o (fifoHead),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .count_o    (fifoCount)
    );

    assign popFire = !fifoEmpty && bus.m_ready;

    // Reads are decided one edge early, so the credit check looks at the occupancy
    // (buffer count plus in-flight word) the issuing cycle will actually see.
    assign occNext   = OCC_W'(fifoCount) + OCC_W'(inflight_q) + OCC_W'(ramEnb_q) - OCC_W'(popFire);
    assign creditOk  = (occNext < OCC_W'(BUF_DEPTH));
    assign drainDone = !inflight_q && !ramEnb_q &&
                       ((fifoCount == '0) || ((fifoCount == CNT_W'(1)) && popFire));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            remain_q       <= '0;
            ramEnb_q       <= 1'b0;
            ramAddrb_q     <= '0;
            enbLast_q      <= 1'b0;
            inflight_q     <= 1'b0;
            inflightLast_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            inflight_q     <= ramEnb_q;
            inflightLast_q <= enbLast_q;
            ramEnb_q       <= 1'b0;
            ramAddrb_q     <= '0;
            enbLast_q      <= 1'b0;
            done_q         <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.len != '0) begin
                            state_q    <= RUN;
                            busy_q     <= 1'b1;
                            ramEnb_q   <= 1'b1;
                            ramAddrb_q <= bus.start_addr;
                            enbLast_q  <= (bus.len == LEN_W'(1));
                            addr_q     <= bus.start_addr + 1'b1;
                            remain_q   <= bus.len - 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (remain_q == '0) begin
                        state_q <= DRAIN;
                    end else if (creditOk) begin
                        ramEnb_q   <= 1'b1;
                        ramAddrb_q <= addr_q;
                        enbLast_q  <= (remain_q == LEN_W'(1));
                        addr_q     <= addr_q + 1'b1;
                        remain_q   <= remain_q - 1'b1;
                    end
                end
                DRAIN: begin
                    if (drainDone) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // the credit check guarantees a capture never lands in a full buffer without a pop
    a_noOverflow: assert property (@(posedge clk) disable iff (rst)
        !(fifoFull && inflight_q && !popFire));

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ram_enb   = ramEnb_q;
    assign bus.ram_addrb = ramAddrb_q;
    assign bus.m_valid   = !fifoEmpty;
    assign bus.m_data    = fifoEmpty ? '0 : fifoHead[DATA_W-1:0];
    assign bus.m_last    = fifoEmpty ? 1'b0 : fifoHead[DATA_W];

endmodule

// File: tb/tb_tpram_stream_reader.sv
// Directed bench for tpram_stream_reader with a behavioural TPRAM preloaded as mem[a] = a + 16'h100.
module tb_tpram_stream_reader;
    import tpram_stream_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wea = 1'b0;
    logic [7:0]  addra = '0;
    logic [15:0] dina = '0;
    logic [15:0] mem [256];
    logic [15:0] ramDataQ = '0;
    int          cycleNum = 0;

    int assertCount = 0;
    int failCount   = 0;

    int          startCycle;
    logic [15:0] gotData [$];
    logic        gotLast [$];
    int          gotCycle [$];
    logic [7:0]  enbAddr [$];
    int          doneCycle, doneCount, busyCount, validCount, creditViol, stallViol;

    tpram_stream_reader_if bus ();

    tpram_stream_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNum <= cycleNum + 1;

    // behavioural TPRAM: port A writes, port B registered read
    always @(posedge clk) begin
        if (wea) mem[addra] <= dina;
        if (bus.ram_enb) ramDataQ <= mem[bus.ram_addrb];
    end
    assign bus.ram_data_o_b = ramDataQ;

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic launchJob(input logic [7:0] a, input logic [8:0] n);
        bus.start      = 1'b1;
        bus.start_addr = a;
        bus.len        = n;
        startCycle     = cycleNum;
        stepCycle();
        bus.start = 1'b0;
    endtask

    // records one job's activity until done (or budget), then steps into IDLE
    task automatic collect(input int maxCycles, input int readyMode, input int restartAt);
        int          issued = 0;
        int          popped = 0;
        logic        prevStall = 1'b0;
        logic [16:0] prevHead = '0;
        gotData.delete(); gotLast.delete(); gotCycle.delete(); enbAddr.delete();
        doneCycle = -1; doneCount = 0; busyCount = 0; validCount = 0;
        creditViol = 0; stallViol = 0;
        for (int c = 0; c < maxCycles; c++) begin
            bus.m_ready = (readyMode == 0) ? 1'b1 : ((c % 3) == 0);
            if (restartAt > 0 && c == restartAt) begin
                bus.start = 1'b1; bus.start_addr = 8'h80; bus.len = 9'd3;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.ram_enb) begin
                if (issued - popped >= BUF_DEPTH_DEF) creditViol++;
                enbAddr.push_back(bus.ram_addrb);
            end
            if (bus.m_valid) begin
                validCount++;
                if (prevStall && ({bus.m_last, bus.m_data} !== prevHead)) stallViol++;
            end
            if (bus.busy) busyCount++;
            if (bus.done) begin doneCount++; doneCycle = cycleNum; end
            if (bus.m_valid && bus.m_ready) begin
                gotData.push_back(bus.m_data);
                gotLast.push_back(bus.m_last);
                gotCycle.push_back(cycleNum);
                popped++;
            end
            if (bus.ram_enb) issued++;
            prevStall = bus.m_valid && !bus.m_ready;
            prevHead  = {bus.m_last, bus.m_data};
            if (bus.done) break;
            stepCycle();
        end
        bus.start   = 1'b0;
        bus.m_ready = 1'b1;
        stepCycle();
    endtask

    task automatic test_reset();
        logic [15:0] zero16 = '0;
        assertCount++; if (bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %0b expected 0", bus.busy); end
        assertCount++; if (bus.done !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done: got %0b expected 0", bus.done); end
        assertCount++; if (bus.ram_enb !== 1'b0) begin failCount++; $display("[TB] FAIL reset_enb: got %0b expected 0", bus.ram_enb); end
        assertCount++; if (bus.ram_addrb !== 8'h00) begin failCount++; $display("[TB] FAIL reset_addrb: got %0h expected 0", bus.ram_addrb); end
        assertCount++; if (bus.m_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %0b expected 0", bus.m_valid); end
        assertCount++; if (bus.m_data !== zero16) begin failCount++; $display("[TB] FAIL reset_data: got %0h expected 0", bus.m_data); end
        assertCount++; if (bus.m_last !== 1'b0) begin failCount++; $display("[TB] FAIL reset_last: got %0b expected 0", bus.m_last); end
        rst = 1'b0;
        stepCycle();
    endtask

    task automatic test_basic();
        launchJob(8'h00, 9'd4);
        collect(60, 0, 0);
        assertCount++; if (gotData.size() != 4) begin failCount++; $display("[TB] FAIL basic_count: got %0d expected 4", gotData.size()); end
        for (int i = 0; i < 4; i++) begin
            logic [15:0] d = (i < gotData.size()) ? gotData[i] : 16'hxxxx;
            logic        l = (i < gotLast.size()) ? gotLast[i] : 1'bx;
            int          t = (i < gotCycle.size()) ? gotCycle[i] : -1;
            assertCount++; if (d !== 16'h100 + 16'(i)) begin failCount++; $display("[TB] FAIL basic_data[%0d]: got %0h expected %0h", i, d, 16'h100 + 16'(i)); end
            assertCount++; if (l !== (i == 3)) begin failCount++; $display("[TB] FAIL basic_last[%0d]: got %0b expected %0b", i, l, (i == 3)); end
            assertCount++; if (t != startCycle + 3 + i) begin failCount++; $display("[TB] FAIL basic_cycle[%0d]: got %0d expected %0d", i, t - startCycle, 3 + i); end
        end
        assertCount++; if (enbAddr.size() != 4) begin failCount++; $display("[TB] FAIL basic_enb_count: got %0d expected 4", enbAddr.size()); end
        assertCount++; if (doneCount != 1) begin failCount++; $display("[TB] FAIL basic_done_count: got %0d expected 1", doneCount); end
        assertCount++; if (doneCycle != startCycle + 7) begin failCount++; $display("[TB] FAIL basic_done_cycle: got %0d expected 7", doneCycle - startCycle); end
        assertCount++; if (busyCount != 6) begin failCount++; $display("[TB] FAIL basic_busy: got %0d expected 6", busyCount); end
    endtask

    task automatic test_wrap();
        logic [7:0]  expAddr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        logic [15:0] expData [4] = '{16'h1FE, 16'h1FF, 16'h100, 16'h101};
        launchJob(8'hFE, 9'd4);
        collect(60, 0, 0);
        for (int i = 0; i < 4; i++) begin
            logic [7:0]  a = (i < enbAddr.size()) ? enbAddr[i] : 8'hxx;
            logic [15:0] d = (i < gotData.size()) ? gotData[i] : 16'hxxxx;
            assertCount++; if (a !== expAddr[i]) begin failCount++; $display("[TB] FAIL wrap_addr[%0d]: got %0h expected %0h", i, a, expAddr[i]); end
            assertCount++; if (d !== expData[i]) begin failCount++; $display("[TB] FAIL wrap_data[%0d]: got %0h expected %0h", i, d, expData[i]); end
        end
        assertCount++; if (gotLast.size() != 4 || gotLast[3] !== 1'b1) begin failCount++; $display("[TB] FAIL wrap_last: got %0d words expected last on word 3", gotLast.size()); end
    endtask

    task automatic test_backpressure();
        launchJob(8'h40, 9'd6);
        collect(200, 1, 0);
        assertCount++; if (gotData.size() != 6) begin failCount++; $display("[TB] FAIL bp_count: got %0d expected 6", gotData.size()); end
        for (int i = 0; i < 6; i++) begin
            logic [15:0] d = (i < gotData.size()) ? gotData[i] : 16'hxxxx;
            logic        l = (i < gotLast.size()) ? gotLast[i] : 1'bx;
            assertCount++; if (d !== 16'h140 + 16'(i)) begin failCount++; $display("[TB] FAIL bp_data[%0d]: got %0h expected %0h", i, d, 16'h140 + 16'(i)); end
            assertCount++; if (l !== (i == 5)) begin failCount++; $display("[TB] FAIL bp_last[%0d]: got %0b expected %0b", i, l, (i == 5)); end
        end
        assertCount++; if (creditViol != 0) begin failCount++; $display("[TB] FAIL bp_credit: got %0d issues at full occupancy expected 0", creditViol); end
        assertCount++; if (stallViol != 0) begin failCount++; $display("[TB] FAIL bp_stable: got %0d head changes while stalled expected 0", stallViol); end
        assertCount++; if (enbAddr.size() != 6) begin failCount++; $display("[TB] FAIL bp_enb_count: got %0d expected 6", enbAddr.size()); end
        assertCount++; if (gotCycle.size() != 6 || doneCycle != gotCycle[5] + 1) begin failCount++; $display("[TB] FAIL bp_done_cycle: got %0d expected one after last handshake", doneCycle); end
    endtask

    task automatic test_len_zero();
        launchJob(8'h30, 9'd0);
        collect(20, 0, 0);
        assertCount++; if (doneCycle != startCycle + 1) begin failCount++; $display("[TB] FAIL zero_done_cycle: got %0d expected 1", doneCycle - startCycle); end
        assertCount++; if (enbAddr.size() != 0) begin failCount++; $display("[TB] FAIL zero_enb: got %0d expected 0", enbAddr.size()); end
        assertCount++; if (validCount != 0) begin failCount++; $display("[TB] FAIL zero_valid: got %0d expected 0", validCount); end
        assertCount++; if (busyCount != 0) begin failCount++; $display("[TB] FAIL zero_busy: got %0d expected 0", busyCount); end
    endtask

    task automatic test_start_while_busy();
        int extra = 0;
        launchJob(8'h50, 9'd8);
        collect(80, 0, 3);
        assertCount++; if (gotData.size() != 8) begin failCount++; $display("[TB] FAIL busy_count: got %0d expected 8", gotData.size()); end
        for (int i = 0; i < 8; i++) begin
            logic [15:0] d = (i < gotData.size()) ? gotData[i] : 16'hxxxx;
            assertCount++; if (d !== 16'h150 + 16'(i)) begin failCount++; $display("[TB] FAIL busy_data[%0d]: got %0h expected %0h", i, d, 16'h150 + 16'(i)); end
        end
        assertCount++; if (doneCount != 1) begin failCount++; $display("[TB] FAIL busy_done_count: got %0d expected 1", doneCount); end
        for (int c = 0; c < 6; c++) begin
            if (bus.m_valid || bus.ram_enb || bus.busy) extra++;
            stepCycle();
        end
        assertCount++; if (extra != 0) begin failCount++; $display("[TB] FAIL busy_ignored: got %0d active cycles after job expected 0", extra); end
    endtask

    task automatic test_reset_mid_job();
        int got = 0;
        launchJob(8'h60, 9'd10);
        bus.m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (bus.m_valid && bus.m_ready) got++;
            stepCycle();
            if (got == 3) break;
        end
        assertCount++; if (got != 3) begin failCount++; $display("[TB] FAIL abort_words: got %0d expected 3", got); end
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        assertCount++; if (bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL abort_busy: got %0b expected 0", bus.busy); end
        assertCount++; if (bus.done !== 1'b0) begin failCount++; $display("[TB] FAIL abort_done: got %0b expected 0", bus.done); end
        assertCount++; if (bus.ram_enb !== 1'b0) begin failCount++; $display("[TB] FAIL abort_enb: got %0b expected 0", bus.ram_enb); end
        assertCount++; if (bus.m_valid !== 1'b0) begin failCount++; $display("[TB] FAIL abort_valid: got %0b expected 0", bus.m_valid); end
        assertCount++; if (bus.m_data !== 16'h0000) begin failCount++; $display("[TB] FAIL abort_data: got %0h expected 0", bus.m_data); end
        launchJob(8'h20, 9'd2);
        collect(40, 0, 0);
        assertCount++; if (gotData.size() != 2) begin failCount++; $display("[TB] FAIL abort_new_count: got %0d expected 2", gotData.size()); end
        for (int i = 0; i < 2; i++) begin
            logic [15:0] d = (i < gotData.size()) ? gotData[i] : 16'hxxxx;
            assertCount++; if (d !== 16'h120 + 16'(i)) begin failCount++; $display("[TB] FAIL abort_new_data[%0d]: got %0h expected %0h", i, d, 16'h120 + 16'(i)); end
        end
        assertCount++; if (doneCount != 1) begin failCount++; $display("[TB] FAIL abort_new_done: got %0d expected 1", doneCount); end
    endtask

    task automatic test_full_256();
        int dataErr = 0;
        int lastErr = 0;
        int gaps = 0;
        launchJob(8'h10, 9'd256);
        collect(400, 0, 0);
        assertCount++; if (gotData.size() != 256) begin failCount++; $display("[TB] FAIL full_count: got %0d expected 256", gotData.size()); end
        for (int i = 0; i < gotData.size(); i++) begin
            logic [7:0] a = 8'h10 + 8'(i);
            if (gotData[i] !== {8'h01, a}) dataErr++;
            if (gotLast[i] !== (i == 255)) lastErr++;
            if (i > 0 && gotCycle[i] != gotCycle[i-1] + 1) gaps++;
        end
        assertCount++; if (dataErr != 0) begin failCount++; $display("[TB] FAIL full_data: got %0d wrong words expected 0", dataErr); end
        assertCount++; if (lastErr != 0) begin failCount++; $display("[TB] FAIL full_last: got %0d wrong last flags expected 0", lastErr); end
        assertCount++; if (gaps != 0) begin failCount++; $display("[TB] FAIL full_bubbles: got %0d gaps expected 0", gaps); end
        assertCount++; if (enbAddr.size() != 256 || enbAddr[255] !== 8'h0F) begin failCount++; $display("[TB] FAIL full_last_addr: got %0d reads expected 256 ending at 0f", enbAddr.size()); end
        assertCount++; if (doneCycle != startCycle + 259) begin failCount++; $display("[TB] FAIL full_done_cycle: got %0d expected 259", doneCycle - startCycle); end
        assertCount++; if (busyCount != 258) begin failCount++; $display("[TB] FAIL full_busy: got %0d expected 258", busyCount); end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.len        = '0;
        bus.m_ready    = 1'b1;
        stepCycle();
        for (int a = 0; a < 256; a++) begin
            wea   = 1'b1;
            addra = 8'(a);
            dina  = 16'h100 + 16'(a);
            stepCycle();
        end
        wea = 1'b0;
        stepCycle();
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len_zero();
        test_start_while_busy();
        test_reset_mid_job();
        test_full_256();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
